// File: rtl/awg_uart_pkg.sv
// Shared definitions for the AWG serial link (transmitter and receiver).
// Provides the transmit FSM state encoding, the frame data width and the
// default baud divider for a 10 MHz clock at 115200 baud.
package awg_uart_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   push, push_data  - write request (ignored while full)
//   pop, pop_data    - read request (ignored while empty); pop_data shows head
//   full, empty      - status flags derived from the registered count
//   count            - occupied entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   tx_data      - byte to queue
//   tx_valid     - tx_data valid; accepted when tx_ready is also high
//   tx_ready     - FIFO not full
//   uart_tx      - registered serial line, idles high
//   tx_busy      - FSM active or bytes still queued
//   fifo_count   - queued bytes
module uart_transmitter
  import awg_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  tx_state_t                   state;
  tx_state_t                   state_next;
  logic [CNT_W-1:0]            baud_cnt;
  logic [CNT_W-1:0]            baud_next;
  logic [IDX_W-1:0]            bit_idx;
  logic [IDX_W-1:0]            idx_next;
  logic [UART_DATA_BITS-1:0]   sh;
  logic [UART_DATA_BITS-1:0]   sh_next;
  logic                        line_next;
  logic                        bit_done;
  logic                        pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_data;

  // Byte queue between the upstream handshake and the serialiser.
  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != IDLE) || !fifo_empty;
  assign bit_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; pops happen only when leaving IDLE or at the end of STOP.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx == IDX_W'(UART_DATA_BITS - 1))) state_next = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; the line register is loaded with the level
  // of the state being entered so uart_tx changes on the same edge.
  always_comb begin
    sh_next   = pop ? fifo_data : sh;
    baud_next = baud_cnt;
    idx_next  = bit_idx;
    line_next = 1'b1;

    if ((state == IDLE) || (state_next == IDLE) || bit_done) baud_next = '0;
    else                                                    baud_next = baud_cnt + CNT_W'(1);

    if ((state != DATA) || (state_next != DATA)) idx_next = '0;
    else if (bit_done)                           idx_next = bit_idx + IDX_W'(1);

    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = sh_next[idx_next];
      default: line_next = 1'b1;
    endcase
  end

  // Baud counter, bit index, shifter and line register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      uart_tx  <= 1'b1;
    end else begin
      baud_cnt <= baud_next;
      bit_idx  <= idx_next;
      sh       <= sh_next;
      uart_tx  <= line_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a byte scoreboard fed by a
// line decoder running alongside the stimulus.
module tb_uart_transmitter;

  localparam int unsigned K = 4;
  localparam int unsigned D = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned acc_cyc     = 0;
  int          frames      = 0;
  int          peak        = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  logic        mon_in  = 1'b0;
  int          mon_pos = 0;
  logic [7:0]  mon_sh  = '0;

  uart_transmitter #(
    .CLKS_PER_BIT (K),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and wait (bounded) until the handshake completes.
  task automatic send(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(tx_ready), 32'd1);
    if (tx_ready) begin
      exp_q.push_back(b);
      @(negedge clk);
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input int budget, output int waited);
    int n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(tx_busy), 32'd0);
    waited = n;
  endtask

  initial begin
    int w;
    int f0;
    int lows;
    logic [7:0] a10;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Line decoder: samples mid-bit, checks start/stop, scores each byte.
    fork
      forever begin
        @(negedge clk);
        if (32'(fifo_count) > 32'(peak)) peak = int'(fifo_count);
        if (!rst_n) begin
          mon_in = 1'b0;
        end else if (!mon_in) begin
          if (uart_tx === 1'b0) begin
            mon_in  = 1'b1;
            mon_pos = 0;
            start_q.push_back(cyc);
          end
        end else begin
          mon_pos++;
          if (mon_pos == 1) check("start_bit", 32'(uart_tx), 32'd0);
          if (mon_pos >= int'(K) + 1 && mon_pos <= 8 * int'(K) + 1 && ((mon_pos - 1) % int'(K)) == 0)
            mon_sh[(mon_pos - 1) / int'(K) - 1] = uart_tx;
          if (mon_pos == 9 * int'(K) + 1) begin
            check("stop_bit", 32'(uart_tx), 32'd1);
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
            frames++;
          end
          if (mon_pos == 10 * int'(K) - 1) mon_in = 1'b0;
        end
      end
    join_none

    // 1. Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("idle_line_high", 32'(lows), 32'd0);

    // 2. Single byte 0xA5
    send(8'hA5);
    tx_valid = 1'b0;
    check("single_pre_start", 32'(uart_tx), 32'd1);
    check("single_count_after_push", 32'(fifo_count), 32'd1);
    @(negedge clk);
    check("single_start_low", 32'(uart_tx), 32'd0);
    check("single_count_after_pop", 32'(fifo_count), 32'd0);
    wait_idle(100, w);
    check("single_frame_len", 32'(w), 32'd40);
    check("single_line_idle", 32'(uart_tx), 32'd1);

    // 3. Back-to-back 0x00, 0xFF, 0x55
    repeat (3) @(negedge clk);
    peak = 0;
    start_q.delete();
    f0 = frames;
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    tx_valid = 1'b0;
    wait_idle(300, w);
    check("b2b_frames", 32'(frames - f0), 32'd3);
    check("b2b_peak", 32'(peak), 32'd2);
    check("b2b_starts", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("b2b_gap1", start_q[1] - start_q[0], 32'd40);
      check("b2b_gap2", start_q[2] - start_q[1], 32'd40);
    end

    // 4. Full FIFO with tx_valid held
    repeat (3) @(negedge clk);
    f0 = frames;
    send(8'h10);
    a10 = 8'(acc_cyc);
    w   = int'(acc_cyc);
    for (int i = 1; i <= 4; i++) send(8'(8'h10 + i));
    check("full_ready_low", 32'(tx_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    send(8'h15);
    tx_valid = 1'b0;
    check("full_0x15_accept_delay", acc_cyc - 32'(w), 32'd42);
    check("full_count_after_0x15", 32'(fifo_count), 32'd4);
    wait_idle(400, w);
    check("full_frames", 32'(frames - f0), 32'd6);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5. Reset mid-frame during DATA bit 3 of 0x3C
    repeat (3) @(negedge clk);
    send(8'h3C);
    send(8'hC3);
    send(8'h7E);
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("midrst_bit3", 32'(uart_tx), 32'd1);
    check("midrst_queued", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("midrst_line_high", 32'(lows), 32'd0);
    f0 = frames;
    send(8'h81);
    tx_valid = 1'b0;
    wait_idle(100, w);
    check("midrst_frames", 32'(frames - f0), 32'd1);
    check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6. Push at the STOP-end edge with one byte queued
    repeat (3) @(negedge clk);
    f0 = frames;
    send(8'h96);
    send(8'h3A);
    tx_valid = 1'b0;
    repeat (39) @(negedge clk);
    check("pp_count_before", 32'(fifo_count), 32'd1);
    check("pp_stop_high", 32'(uart_tx), 32'd1);
    send(8'hC7);
    tx_valid = 1'b0;
    check("pp_count_after", 32'(fifo_count), 32'd1);
    check("pp_next_start", 32'(uart_tx), 32'd0);
    wait_idle(200, w);
    check("pp_frames", 32'(frames - f0), 32'd3);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
